// File: rtl/is_uart_tx_arbiter_pkg.sv
// Shared UART controller package: frame width, default bit period,
// transmit FSM states and the round-robin pick helper.
package is_pkg_uart_controller;

   localparam int DATA_W           = 8;
   localparam int CLKS_PER_BIT_DEF = 868;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   // Index of the winning requester; a tie goes to whoever did not win last.
   function automatic logic rr_pick(
      input logic v0,
      input logic v1,
      input logic last
   );
      if (v0 && v1) return !last;
      return v1;
   endfunction

endpackage

// File: rtl/is_uart_tx_arbiter_if.sv
// Byte request bundle for the two command paths feeding the UART arbiter.
// master = requester side, slave = arbiter side.
interface is_uart_tx_arbiter_if;
   import is_pkg_uart_controller::*;

   logic              req0_valid_i;
   logic [DATA_W-1:0] req0_data_i;
   logic              req0_ready_o;
   logic              req1_valid_i;
   logic [DATA_W-1:0] req1_data_i;
   logic              req1_ready_o;

   modport master (
      output req0_valid_i,
      output req0_data_i,
      input  req0_ready_o,
      output req1_valid_i,
      output req1_data_i,
      input  req1_ready_o
   );

   modport slave (
      input  req0_valid_i,
      input  req0_data_i,
      output req0_ready_o,
      input  req1_valid_i,
      input  req1_data_i,
      output req1_ready_o
   );

endinterface

// File: rtl/is_uart_baud_cnt.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while enabled, held at 0 by clear.
// pre_end fires one cycle before bit_end so callers can register end pulses.
module is_uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic clear,
   input  logic enable,
   output logic bit_end,
   output logic pre_end
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk_i) begin
      if (!rstn_i || clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   assign bit_end = enable && !clear && (cnt == LAST);
   assign pre_end = enable && !clear && (cnt == PRE);

endmodule

// File: rtl/is_uart_tx_arbiter.sv
// Round-robin share of one UART TX line between two byte requesters,
// each accepted byte sent as start + DATA_W bits LSB first + stop.
module is_uart_tx_arbiter
   import is_pkg_uart_controller::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   is_uart_tx_arbiter_if.slave  req,
   output logic                 tx_o,
   output logic                 busy_o,
   output logic                 grant_o,
   output logic                 frame_done_o
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   tx_state_t         state;
   logic              last_grant;
   logic              winner;
   logic              xfer;
   logic [DATA_W-1:0] win_data;
   logic [DATA_W-1:0] shift;
   logic [DATA_W-1:0] nxt_shift;
   logic [IDX_W-1:0]  bit_idx;
   logic              bit_end;
   logic              pre_end;

   always_comb begin
      winner   = rr_pick(req.req0_valid_i, req.req1_valid_i, last_grant);
      win_data = winner ? req.req1_data_i : req.req0_data_i;
      req.req0_ready_o = rstn_i && (state == TX_IDLE)
                       && req.req0_valid_i && !winner;
      req.req1_ready_o = rstn_i && (state == TX_IDLE)
                       && req.req1_valid_i && winner;
      xfer      = req.req0_ready_o || req.req1_ready_o;
      nxt_shift = shift >> 1;
   end

   is_uart_baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .clear   (state == TX_IDLE),
      .enable  (state != TX_IDLE),
      .bit_end (bit_end),
      .pre_end (pre_end)
   );

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state        <= TX_IDLE;
         last_grant   <= 1'b1;
         grant_o      <= 1'b0;
         tx_o         <= 1'b1;
         busy_o       <= 1'b0;
         frame_done_o <= 1'b0;
         shift        <= '0;
         bit_idx      <= '0;
      end else begin
         frame_done_o <= 1'b0;
         unique case (state)
            TX_IDLE: begin
               if (xfer) begin
                  state      <= TX_START;
                  shift      <= win_data;
                  grant_o    <= winner;
                  last_grant <= winner;
                  bit_idx    <= '0;
                  tx_o       <= 1'b0;
                  busy_o     <= 1'b1;
               end
            end
            TX_START: begin
               if (bit_end) begin
                  state <= TX_DATA;
                  tx_o  <= shift[0];
               end
            end
            TX_DATA: begin
               if (bit_end) begin
                  shift   <= nxt_shift;
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == LAST_IDX) begin
                     state <= TX_STOP;
                     tx_o  <= 1'b1;
                  end else begin
                     tx_o  <= nxt_shift[0];
                  end
               end
            end
            TX_STOP: begin
               // Registered pulse lands on the final stop-bit cycle.
               if (pre_end) frame_done_o <= 1'b1;
               if (bit_end) begin
                  state  <= TX_IDLE;
                  busy_o <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/is_uart_tx_arbiter.md
# is_uart_tx_arbiter

Shares the single UART transmit line between two byte requesters, which are the two debounced-button command paths, using round-robin arbitration. Serialises each accepted byte as a standard 8N1-style frame (start, DATA_W data bits LSB first, one stop) at a fixed bit period. The block sits between the button/command logic and the `uart_data_tx_o` pin path in the UART top.

## Interface
- `DATA_W`, default 8: data bits per frame. Taken from the shared package.
- `CLKS_PER_BIT`, default 868: `clk_i` cycles per bit (100 MHz / 115200). Legal range ≥ 2.
- `clk_i`  in  1  system clock; all logic is in this one domain.
- `rstn_i`  in  1  reset, synchronous, active-low.
- `req0_valid_i`  in  1  requester 0 has a byte to send.
- `req0_data_i`  in  DATA_W  requester 0 byte.
- `req0_ready_o`  out  1  requester 0 byte accepted this cycle.
- `req1_valid_i`  in  1  requester 1 has a byte to send.
- `req1_data_i`  in  DATA_W  requester 1 byte.
- `req1_ready_o`  out  1  requester 1 byte accepted this cycle.
- `tx_o`  out  1  serial line; idles high.
- `busy_o`  out  1  a frame is in progress.
- `grant_o`  out  1  index of the requester that owns the current or last frame.
- `frame_done_o`  out  1  one-cycle pulse at the end of the stop bit.

## Operation
- **States:** IDLE, START, DATA, STOP.
- **Transfer rule:** a transfer occurs when `reqN_valid_i && reqN_ready_o` are both high on the same cycle.
- **Ready generation:** `reqN_ready_o` is combinational. It is high only in IDLE, only for the arbitration winner, and only while that requester's valid is high.
- **Arbitration:**
  - One requester valid: that requester wins.
  - Both valid: the winner is `!last_grant`.
  - `last_grant` updates to the winner on each transfer.
- **IDLE → START:** on a transfer. The winner's data is latched into the shift register, `grant_o` is set to the winner, and the bit counter is cleared.
- **START:** `tx_o` = 0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA:** `tx_o` = `shift[0]`. At the end of each bit period, shift right and increment the bit index. After bit DATA_W-1 completes, go to STOP.
- **STOP:** `tx_o` = 1 for CLKS_PER_BIT cycles. On the last cycle, pulse `frame_done_o` and go to IDLE.
- **busy_o:** high in START, DATA and STOP.
- **Valid handling:** valid may drop or data may change at any time without a transfer, with no effect. Requester data is sampled only on the transfer cycle. A requester must not assume acceptance without seeing ready.
- **Baud counter:** counts 0..CLKS_PER_BIT-1, with width `$clog2(CLKS_PER_BIT)`. It restarts at 0 on every state entry. The bit index has width `$clog2(DATA_W)`.
- **Reset values** (`rstn_i` low at a rising edge):
  - `tx_o` = 1
  - `busy_o` = 0
  - `grant_o` = 0
  - `frame_done_o` = 0
  - state = IDLE
  - `last_grant` = 1, so requester 0 wins the first tie.
  - Ready outputs are 0 while reset is asserted.
- **Reset mid-frame:** the frame is aborted and `tx_o` returns high at the next edge. The requester already got its ready, so no retry is generated.

## Timing
- **Latency:** transfer at edge T makes `tx_o` fall in the cycle after T, i.e. it is registered.
- **Bit duration:** each bit is exactly CLKS_PER_BIT cycles.
- **Frame length:** (DATA_W+2)·CLKS_PER_BIT cycles, measured from the first start-bit cycle to the last stop-bit cycle inclusive.
- **frame_done_o:** coincides with the last stop-bit cycle.
- **Back-to-back frames:**
  - IDLE always lasts at least one cycle.
  - The earliest next ready is the cycle after `frame_done_o`.
  - Minimum inter-frame gap: one extra idle-high cycle.
- **Simultaneous events:** both requesters valid in IDLE produce exactly one ready, per the round-robin rule. Valid arriving during a frame is held until IDLE.
- **Output registration:** `tx_o`, `busy_o`, `grant_o` and `frame_done_o` are registered. The ready outputs are the only combinational outputs.

## Structure
- **Shared package `is_pkg_uart_controller`:** owns `DATA_W` (already there). Add:
  - `tx_state_t`, an enum for IDLE/START/DATA/STOP.
  - `CLKS_PER_BIT_DEF` = 868.
- **Sub-module `is_uart_baud_cnt`:** the bit-period counter.
  - Inputs: clear, enable.
  - Output: `bit_end` pulse on count CLKS_PER_BIT-1.
- **Top-level logic:** arbitration, the FSM and the shift register stay in the top module.

## Test plan
All scenarios run with CLKS_PER_BIT=4 and DATA_W=8.
- **Reset / idle:** hold reset 3 cycles, no valids → `tx_o`=1, `busy_o`=0, both readies 0 for 50 cycles.
- **Single frame:** `req0_valid_i`=1, data 0xA5 → one-cycle `req0_ready_o`. `tx_o` then shows 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. `frame_done_o` pulses on cycle 40 after the transfer. `grant_o`=0.
- **Tie, round-robin:**
  - Both valid, req0=0x11 and req1=0x22, held high → frames go 0x11 (grant 0), 0x22 (grant 1), 0x11 (grant 0).
  - Each inter-frame gap is exactly 1 idle cycle.
- **Late request:** `req1_valid_i` is raised mid-frame of a req0 byte → `req1_ready_o` stays 0 until the cycle after `frame_done_o`, then req1's frame is sent.
- **Reset mid-frame:** assert `rstn_i` low during data bit 3 of 0x00 → `tx_o`=1 at the next edge, `busy_o`=0, no `frame_done_o`. After release, a new 0x5A frame is sent correctly.
- **Valid withdrawal:** `req0_valid_i` pulses for one cycle while busy → no frame is ever sent for it and `tx_o` stays idle afterwards.
